// File: rtl/wave_freq_meter.sv
// Recovers the fundamental frequency of a 16-bit offset-binary sample stream:
// a hysteretic rising-crossing detector times the period, a serial divider turns it into Hz.
module wave_freq_meter #(
  parameter int unsigned SAMPLE_HZ = 50000000,
  parameter int unsigned HYST      = 1024,
  parameter int unsigned PERIOD_W  = 24,
  parameter int unsigned TIMEOUT   = 16777215
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [15:0]         wave,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [19:0]         freq,
  output logic                freq_valid,
  output logic                no_signal,
  output logic                busy
);

  localparam int unsigned MID    = 32768;
  localparam int unsigned DIV_W  = 32;
  localparam int unsigned REM_W  = PERIOD_W + 1;
  localparam int unsigned ITER_W = 6;
  localparam int unsigned FREQ_W = 20;

  localparam logic [15:0]         LO       = 16'(MID - HYST);
  localparam logic [15:0]         HI       = 16'(MID + HYST);
  localparam logic [PERIOD_W-1:0] TMO      = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] TMO_M1   = PERIOD_W'(TIMEOUT - 1);
  localparam logic [DIV_W-1:0]    DIVIDEND = DIV_W'(SAMPLE_HZ);
  localparam logic [ITER_W-1:0]   LAST_IT  = ITER_W'(DIV_W);
  localparam logic [FREQ_W-1:0]   FREQ_MAX = '1;

  typedef enum logic {SEEK_LOW, ARMED} det_e;
  typedef enum logic [1:0] {IDLE, DIV, DONE} div_e;

  det_e det_q, det_d;
  logic crossing_c;

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                locked_q, locked_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                nosig_q, nosig_d;

  div_e                div_q, div_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [PERIOD_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]    quo_q, quo_d;
  logic [PERIOD_W-1:0] dvs_q, dvs_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                fv_q, fv_d;
  logic                pending_q, pending_d;
  logic                busy_q, busy_d;
  logic [REM_W-1:0]    rem_sh;
  logic [REM_W-1:0]    rem_diff;

  // Detector state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) det_q <= SEEK_LOW;
    else          det_q <= det_d;
  end

  // Detector next state: only a sample outside the hysteresis band moves it
  always_comb begin
    det_d = det_q;
    if (sample_en) begin
      case (det_q)
        SEEK_LOW: if (wave < LO)  det_d = ARMED;
        ARMED:    if (wave >= HI) det_d = SEEK_LOW;
        default:  det_d = SEEK_LOW;
      endcase
    end
  end

  // Detector output
  always_comb begin
    crossing_c = sample_en && (det_q == ARMED) && (wave >= HI);
  end

  // Period counter, lock tracking and timeout; a crossing beats a same-sample timeout
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    period_d = period_q;
    pv_d     = 1'b0;
    nosig_d  = nosig_q;
    if (sample_en) begin
      if (crossing_c) begin
        cnt_d    = PERIOD_W'(1);
        locked_d = 1'b1;
        if (locked_q) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          nosig_d  = 1'b0;
        end
      end else if (cnt_q != TMO) begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (cnt_q == TMO_M1) begin
          nosig_d  = 1'b1;
          locked_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      nosig_q  <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      nosig_q  <= nosig_d;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= IDLE;
    else          div_q <= div_d;
  end

  // Divider next state; a pending period reloads straight from DONE
  always_comb begin
    div_d = div_q;
    case (div_q)
      IDLE:    if (pv_q) div_d = DIV;
      DIV:     if (iter_q == LAST_IT) div_d = DONE;
      DONE:    div_d = (pending_q || pv_q) ? DIV : IDLE;
      default: div_d = IDLE;
    endcase
  end

  assign rem_sh   = {rem_q, quo_q[DIV_W-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};

  // Divider datapath: iteration 0 loads, iterations 1..32 each retire one quotient bit
  always_comb begin
    iter_d    = iter_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    freq_d    = freq_q;
    fv_d      = 1'b0;
    pending_d = pending_q;
    busy_d    = (div_d != IDLE);
    case (div_q)
      IDLE: begin
        if (div_d == DIV) iter_d = '0;
      end
      DIV: begin
        if (pv_q) pending_d = 1'b1;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == '0) begin
          rem_d = '0;
          quo_d = DIVIDEND;
          dvs_d = period_q;
        end else begin
          if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = rem_diff[PERIOD_W-1:0];
            quo_d = {quo_q[DIV_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[PERIOD_W-1:0];
            quo_d = {quo_q[DIV_W-2:0], 1'b0};
          end
          if (iter_q == LAST_IT) begin
            freq_d = (|quo_d[DIV_W-1:FREQ_W]) ? FREQ_MAX : quo_d[FREQ_W-1:0];
            fv_d   = 1'b1;
          end
        end
      end
      DONE: begin
        pending_d = 1'b0;
        if (div_d == DIV) iter_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      freq_q    <= '0;
      fv_q      <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      iter_q    <= iter_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      freq_q    <= freq_d;
      fv_q      <= fv_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign freq         = freq_q;
  assign freq_valid   = fv_q;
  assign no_signal    = nosig_q;
  assign busy         = busy_q;

endmodule

// File: doc/wave_freq_meter.md
Name: wave_freq_meter

Overview:
- Measures the fundamental frequency of a 16-bit sample stream, such as the oscillator output.
- This is the inverse path of the oscillator: the oscillator turns freq into wave, this block turns wave back into freq in Hz.
- Detects rising mid-level crossings with hysteresis, counts samples between crossings, then converts the period to Hz with an iterative divider.
- Used for on-chip self-check of tuning and as a tuner/readout source.

Parameters:
- SAMPLE_HZ, 50000000, sample rate in Hz; dividend for the frequency calculation.
- HYST, 1024, hysteresis half-width around mid-scale 32768.
- PERIOD_W, 24, width of the period counter and divider.
- TIMEOUT, 16777215, sample count with no crossing that declares no_signal; must be ≤ 2^PERIOD_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sample_en  input  1  qualifies wave; one new sample per high cycle.
- wave  input  16  unsigned offset-binary sample, mid-scale 32768.
- period  output  PERIOD_W  last measured period in samples.
- period_valid  output  1  one-cycle pulse when period updates.
- freq  output  20  SAMPLE_HZ/period in Hz, truncated; saturates at 1048575.
- freq_valid  output  1  one-cycle pulse when freq updates.
- no_signal  output  1  high when no valid crossing within TIMEOUT samples.
- busy  output  1  divider running.

Behaviour:
- Reset, asynchronous, active-low:
  - period=0, period_valid=0, freq=0, freq_valid=0, no_signal=1, busy=0.
  - Detector in SEEK_LOW, counter=0, pending=0.
- Nothing in the detector advances on cycles with sample_en=0.
- Thresholds: LO = 32768-HYST, HI = 32768+HYST, compared unsigned.
- Detector FSM, evaluated on sample_en cycles:
  - SEEK_LOW: wave < LO → ARMED.
  - ARMED: wave ≥ HI → crossing event, then → SEEK_LOW.
  - A sample between LO and HI never changes state. This is the hysteresis.
- Measurement flag `locked`, cleared by reset and by timeout:
  - First crossing while !locked: set locked, counter=1, no output.
  - Crossing while locked: period ← counter, period_valid pulses the following cycle, counter=1, no_signal ← 0.
  - A crossing sample counts as sample 1 of the next period. A square wave toggling every N samples therefore gives period=2N.
- Counter: increments on each sample_en cycle with no crossing.
  - On reaching TIMEOUT: no_signal ← 1, locked ← 0, counter holds at TIMEOUT.
  - period and freq keep their last values.
- Divider FSM (IDLE, DIV, DONE):
  - Start: in IDLE, period_valid pulse → DIV.
  - DIV runs a restoring shift-subtract, one quotient bit per cycle, PERIOD_W+? cycles fixed, 32 iterations using a 32-bit dividend.
  - DONE: quotient above 20 bits saturates to 1048575. freq updates and freq_valid pulses in the DONE cycle, then → IDLE.
  - Latency: freq_valid asserts exactly 34 cycles after the period_valid cycle (1 load + 32 iterations + 1 done).
  - busy is high from the load cycle through DONE.
- New period_valid while busy:
  - Set pending.
  - On DONE with pending: clear pending and go directly to load using the current period register (latest value wins), with no IDLE cycle.
  - Intermediate periods get no freq.
- Simultaneous crossing and timeout on the same sample: crossing wins and the counter resets.
- Mid-operation reset: aborts the divider and clears pending. No freq_valid is emitted.
- period=0 cannot occur, since the minimum period is 2.

Test Plan:
- Reset: hold reset_n=0 with sample_en toggling and wave swinging → all outputs at reset values, no pulses. Release reset → no_signal stays 1 until the second crossing.
- Square wave: SAMPLE_HZ=1000, sample_en=1 every clock, wave alternating 0x0000/0xFFFF every 5 samples → period=10 on the second crossing. freq=100 with freq_valid exactly 34 cycles after period_valid. no_signal=0.
- Hysteresis: SAMPLE_HZ=1000, HYST=1024, wave alternating 32768±500 for 200 samples → no period_valid, no_signal stays 1. Switching to ±2000 with period 8 → period=8, freq=125.
- sample_en gating: sample_en high one cycle in three, square period 20 samples → period=20, independent of clock count.
- Saturation and back-to-back: SAMPLE_HZ=50000000, period=2 → freq=1048575. A new period arriving while busy → exactly one extra freq_valid, carrying the latest period.
- Timeout: TIMEOUT=100, lock on a period-10 square, then hold wave=0x8000 → no_signal=1 at sample 100 after the last crossing; period and freq keep old values. Resuming the wave → first crossing gives no output, second gives period_valid.
